bcd_digit_ssd_cnt: RTL and testbench

Parametrised, cascadable single-digit counter with a registered seven-segment output. It is the common building block for all timer digit positions (seconds, minutes, hours) and replaces the per-position fixed-modulus digit modules. It adds a configurable modulus, up/down counting, synchronous load and clear, a carry/borrow chain and display blanking. Digit positions are chained through `carry_out` → `cnt_en`, so no position decodes another position's segment pattern.

---
 rtl/timer_ssd_pkg.sv | 46 ++++
 rtl/bcd_digit_ssd_cnt_if.sv | 25 ++
 rtl/ssd_encoder.sv | 20 ++
 rtl/bcd_digit_ssd_cnt.sv | 70 +++++++
 tb/tb_bcd_digit_ssd_cnt.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_ssd_pkg.sv
// Shared seven-segment constants and encoder function for every timer digit.
// Segment bit order is {g,f,e,d,c,b,a}, active-high before any polarity inversion.
package timer_ssd_pkg;

  localparam logic [6:0] SSD_ZERO  = 7'h3F;
  localparam logic [6:0] SSD_ONE   = 7'h06;
  localparam logic [6:0] SSD_TWO   = 7'h5B;
  localparam logic [6:0] SSD_THREE = 7'h4F;
  localparam logic [6:0] SSD_FOUR  = 7'h66;
  localparam logic [6:0] SSD_FIVE  = 7'h6D;
  localparam logic [6:0] SSD_SIX   = 7'h7D;
  localparam logic [6:0] SSD_SEVEN = 7'h07;
  localparam logic [6:0] SSD_EIGHT = 7'h7F;
  localparam logic [6:0] SSD_NINE  = 7'h6F;
  localparam logic [6:0] SSD_A     = 7'h77;
  localparam logic [6:0] SSD_B     = 7'h7C;
  localparam logic [6:0] SSD_C     = 7'h39;
  localparam logic [6:0] SSD_D     = 7'h5E;
  localparam logic [6:0] SSD_E     = 7'h79;
  localparam logic [6:0] SSD_F     = 7'h71;
  localparam logic [6:0] SSD_BLANK = 7'h00;

  function automatic logic [6:0] bcd_to_ssd(input logic [3:0] val);
    logic [6:0] seg;
    unique case (val)
      4'd0:    seg = SSD_ZERO;
      4'd1:    seg = SSD_ONE;
      4'd2:    seg = SSD_TWO;
      4'd3:    seg = SSD_THREE;
      4'd4:    seg = SSD_FOUR;
      4'd5:    seg = SSD_FIVE;
      4'd6:    seg = SSD_SIX;
      4'd7:    seg = SSD_SEVEN;
      4'd8:    seg = SSD_EIGHT;
      4'd9:    seg = SSD_NINE;
      4'd10:   seg = SSD_A;
      4'd11:   seg = SSD_B;
      4'd12:   seg = SSD_C;
      4'd13:   seg = SSD_D;
      4'd14:   seg = SSD_E;
      default: seg = SSD_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_digit_ssd_cnt_if.sv
// Control and status bundle of one counter digit; the digit itself is the slave.
interface bcd_digit_ssd_cnt_if;

  logic       cnt_en;
  logic       dir;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic       blank;
  logic [3:0] digit;
  logic       carry_out;
  logic       load_err;
  logic [6:0] ssd;

  modport master (
    output cnt_en, dir, clr, load, load_val, blank,
    input  digit, carry_out, load_err, ssd
  );

  modport slave (
    input  cnt_en, dir, clr, load, load_val, blank,
    output digit, carry_out, load_err, ssd
  );

endinterface

// File: rtl/ssd_encoder.sv
// Combinational 4-bit to seven-segment encoder with blanking and optional
// common-anode inversion, applied after blanking so "off" is inverted too.
module ssd_encoder
  import timer_ssd_pkg::*;
#(
  parameter bit SEG_ACT_LOW = 1'b0
) (
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] seg_raw;

  always_comb begin
    seg_raw = blank ? SSD_BLANK : bcd_to_ssd(value);
    seg     = seg_raw ^ {7{SEG_ACT_LOW}};
  end

endmodule

// File: rtl/bcd_digit_ssd_cnt.sv
// Cascadable modulo-MOD up/down digit counter with load/clear, carry chain and
// a registered seven-segment output that always tracks the digit register.
module bcd_digit_ssd_cnt
  import timer_ssd_pkg::*;
#(
  parameter int unsigned MOD         = 10,
  parameter bit          SEG_ACT_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_digit_ssd_cnt_if.slave  bus
);

  localparam logic [3:0] MAX_VAL = 4'(MOD - 1);
  localparam logic [4:0] MOD_W   = 5'(MOD);

  logic [3:0] digit_q;
  logic [3:0] digit_d;
  logic [6:0] ssd_q;
  logic [6:0] ssd_d;
  logic       load_err_q;
  logic       load_oor;
  logic       at_limit;

  assign at_limit = bus.dir ? (digit_q == 4'd0) : (digit_q == MAX_VAL);
  // Only an effective load can flag an error; a simultaneous clear wins.
  assign load_oor = bus.load && !bus.clr && ({1'b0, bus.load_val} >= MOD_W);

  always_comb begin
    digit_d = digit_q;
    if (bus.clr) begin
      digit_d = 4'd0;
    end else if (bus.load) begin
      digit_d = load_oor ? MAX_VAL : bus.load_val;
    end else if (bus.cnt_en) begin
      if (at_limit) begin
        digit_d = bus.dir ? MAX_VAL : 4'd0;
      end else begin
        digit_d = bus.dir ? (digit_q - 4'd1) : (digit_q + 4'd1);
      end
    end
  end

  // Encoding the next digit keeps ssd in step with digit on the same edge.
  ssd_encoder #(
    .SEG_ACT_LOW (SEG_ACT_LOW)
  ) u_enc (
    .value (digit_d),
    .blank (bus.blank),
    .seg   (ssd_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_q    <= 4'd0;
      ssd_q      <= SSD_BLANK ^ {7{SEG_ACT_LOW}};
      load_err_q <= 1'b0;
    end else begin
      digit_q    <= digit_d;
      ssd_q      <= ssd_d;
      load_err_q <= load_oor;
    end
  end

  assign bus.digit     = digit_q;
  assign bus.ssd       = ssd_q;
  assign bus.load_err  = load_err_q;
  assign bus.carry_out = bus.cnt_en & ~bus.clr & ~bus.load & rst_n & at_limit;

endmodule

// File: tb/tb_bcd_digit_ssd_cnt.sv
// Bench for bcd_digit_ssd_cnt: five digits (modulo 6, modulo 10, a 10/6 cascade and a
// modulo-16 common-anode digit) checked against an arithmetic model every cycle.
module tb_bcd_digit_ssd_cnt;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_digit_ssd_cnt_if if6 ();
  bcd_digit_ssd_cnt_if if10 ();
  bcd_digit_ssd_cnt_if iflo ();
  bcd_digit_ssd_cnt_if ifhi ();
  bcd_digit_ssd_cnt_if if16 ();

  assign ifhi.cnt_en = iflo.carry_out;

  bcd_digit_ssd_cnt #(.MOD(6),  .SEG_ACT_LOW(1'b0)) u_mod6  (.clk(clk), .rst_n(rst_n), .bus(if6));
  bcd_digit_ssd_cnt #(.MOD(10), .SEG_ACT_LOW(1'b0)) u_mod10 (.clk(clk), .rst_n(rst_n), .bus(if10));
  bcd_digit_ssd_cnt #(.MOD(10), .SEG_ACT_LOW(1'b0)) u_sec_lo (.clk(clk), .rst_n(rst_n), .bus(iflo));
  bcd_digit_ssd_cnt #(.MOD(6),  .SEG_ACT_LOW(1'b0)) u_sec_hi (.clk(clk), .rst_n(rst_n), .bus(ifhi));
  bcd_digit_ssd_cnt #(.MOD(16), .SEG_ACT_LOW(1'b1)) u_hex_al (.clk(clk), .rst_n(rst_n), .bus(if16));

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  typedef struct {
    int         d;
    logic [6:0] ssd;
    logic       lerr;
  } model_t;

  // Conventional {g,f,e,d,c,b,a} patterns for 0-9 and A-F.
  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  model_t m6  = '{0, 7'h00, 1'b0};
  model_t m10 = '{0, 7'h00, 1'b0};
  model_t mlo = '{0, 7'h00, 1'b0};
  model_t mhi = '{0, 7'h00, 1'b0};
  model_t m16 = '{0, 7'h7F, 1'b0};

  function automatic bit model_carry(model_t m, int md, logic rn, logic en, logic dn,
                                     logic cl, logic ld);
    return rn && en && !cl && !ld && (dn ? (m.d == 0) : (m.d == md - 1));
  endfunction

  function automatic model_t model_step(model_t m, int md, bit act_low, logic rn, logic en,
                                        logic dn, logic cl, logic ld, logic [3:0] lv,
                                        logic bl);
    model_t n;
    n = m;
    n.lerr = 1'b0;
    if (!rn) begin
      n.d   = 0;
      n.ssd = 7'h00 ^ {7{act_low}};
      return n;
    end
    if (cl) begin
      n.d = 0;
    end else if (ld) begin
      if (int'(lv) < md) begin
        n.d = int'(lv);
      end else begin
        n.d    = md - 1;
        n.lerr = 1'b1;
      end
    end else if (en) begin
      n.d = dn ? (m.d + md - 1) % md : (m.d + 1) % md;
    end
    n.ssd = (bl ? 7'h00 : seg_tbl[n.d]) ^ {7{act_low}};
    return n;
  endfunction

  // Model advances on every rising edge from the inputs held across it.
  always @(posedge clk) begin
    m6  <= model_step(m6, 6, 1'b0, rst_n, if6.cnt_en, if6.dir, if6.clr, if6.load,
                      if6.load_val, if6.blank);
    m10 <= model_step(m10, 10, 1'b0, rst_n, if10.cnt_en, if10.dir, if10.clr, if10.load,
                      if10.load_val, if10.blank);
    mlo <= model_step(mlo, 10, 1'b0, rst_n, iflo.cnt_en, iflo.dir, iflo.clr, iflo.load,
                      iflo.load_val, iflo.blank);
    mhi <= model_step(mhi, 6, 1'b0, rst_n,
                      model_carry(mlo, 10, rst_n, iflo.cnt_en, iflo.dir, iflo.clr, iflo.load),
                      ifhi.dir, ifhi.clr, ifhi.load, ifhi.load_val, ifhi.blank);
    m16 <= model_step(m16, 16, 1'b1, rst_n, if16.cnt_en, if16.dir, if16.clr, if16.load,
                      if16.load_val, if16.blank);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareDigit(input string name, input logic [3:0] dig, input logic [6:0] seg,
                              input logic lerr, input logic carry, input model_t m,
                              input bit exp_carry);
    checkOutput({name, ".digit"}, 32'(dig), 32'(m.d));
    checkOutput({name, ".ssd"}, 32'(seg), 32'(m.ssd));
    checkOutput({name, ".load_err"}, 32'(lerr), 32'(m.lerr));
    checkOutput({name, ".carry_out"}, 32'(carry), 32'(exp_carry));
  endtask

  // Mid-cycle comparison of every digit against the model.
  always @(negedge clk) begin
    if (check_en) begin
      compareDigit("mod6", if6.digit, if6.ssd, if6.load_err, if6.carry_out, m6,
                   model_carry(m6, 6, rst_n, if6.cnt_en, if6.dir, if6.clr, if6.load));
      compareDigit("mod10", if10.digit, if10.ssd, if10.load_err, if10.carry_out, m10,
                   model_carry(m10, 10, rst_n, if10.cnt_en, if10.dir, if10.clr, if10.load));
      compareDigit("sec_lo", iflo.digit, iflo.ssd, iflo.load_err, iflo.carry_out, mlo,
                   model_carry(mlo, 10, rst_n, iflo.cnt_en, iflo.dir, iflo.clr, iflo.load));
      compareDigit("sec_hi", ifhi.digit, ifhi.ssd, ifhi.load_err, ifhi.carry_out, mhi,
                   model_carry(mhi, 6, rst_n,
                               model_carry(mlo, 10, rst_n, iflo.cnt_en, iflo.dir, iflo.clr,
                                           iflo.load),
                               ifhi.dir, ifhi.clr, ifhi.load));
      compareDigit("hex_al", if16.digit, if16.ssd, if16.load_err, if16.carry_out, m16,
                   model_carry(m16, 16, rst_n, if16.cnt_en, if16.dir, if16.clr, if16.load));
    end
  end

  // Let n rising edges pass, returning just after the last one.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int exp6 [7];
    int prev;
    exp6 = '{1, 2, 3, 4, 5, 0, 1};

    rst_n = 1'b0;
    {if6.cnt_en, if6.dir, if6.clr, if6.load, if6.blank} = '0;
    if6.load_val = 4'd0;
    {if10.cnt_en, if10.dir, if10.clr, if10.load, if10.blank} = '0;
    if10.load_val = 4'd0;
    {iflo.cnt_en, iflo.dir, iflo.clr, iflo.load, iflo.blank} = '0;
    iflo.load_val = 4'd0;
    {ifhi.dir, ifhi.clr, ifhi.load, ifhi.blank} = '0;
    ifhi.load_val = 4'd0;
    {if16.cnt_en, if16.dir, if16.clr, if16.load, if16.blank} = '0;
    if16.load_val = 4'd0;

    applyStimulus(2);
    check_en = 1'b1;
    checkOutput("rst.digit", 32'(if6.digit), 0);
    checkOutput("rst.ssd", 32'(if6.ssd), 32'h00);
    checkOutput("rst.load_err", 32'(if6.load_err), 0);
    checkOutput("rst.ssd_act_low", 32'(if16.ssd), 32'h7F);
    if16.cnt_en = 1'b1;
    if16.dir    = 1'b1;
    #1;
    checkOutput("rst.carry_held", 32'(if16.carry_out), 0);
    if16.cnt_en = 1'b0;
    if16.dir    = 1'b0;

    rst_n = 1'b1;
    applyStimulus(1);
    checkOutput("idle.ssd_zero", 32'(if6.ssd), 32'h3F);
    checkOutput("idle.ssd_zero_al", 32'(if16.ssd), 32'h40);

    // Modulo-6 digit counting up through a wrap.
    if6.cnt_en = 1'b1;
    prev = 0;
    for (int i = 0; i < 7; i++) begin
      #1;
      checkOutput("mod6.carry", 32'(if6.carry_out), 32'(prev == 5));
      applyStimulus(1);
      checkOutput("mod6.digit", 32'(if6.digit), 32'(exp6[i]));
      prev = exp6[i];
    end
    if6.cnt_en = 1'b0;

    // Modulo-10 digit counting down from 0 borrows.
    if10.dir    = 1'b1;
    if10.cnt_en = 1'b1;
    #1;
    checkOutput("down.borrow", 32'(if10.carry_out), 1);
    applyStimulus(1);
    checkOutput("down.wrap", 32'(if10.digit), 9);
    checkOutput("down.ssd9", 32'(if10.ssd), 32'h6F);
    checkOutput("down.no_borrow", 32'(if10.carry_out), 0);
    applyStimulus(1);
    checkOutput("down.eight", 32'(if10.digit), 8);
    if10.cnt_en = 1'b0;
    if10.dir    = 1'b0;

    // Out-of-range load saturates and pulses load_err once.
    if10.load     = 1'b1;
    if10.load_val = 4'd12;
    applyStimulus(1);
    checkOutput("load12.digit", 32'(if10.digit), 9);
    checkOutput("load12.err", 32'(if10.load_err), 1);
    if10.load_val = 4'd7;
    applyStimulus(1);
    checkOutput("load7.digit", 32'(if10.digit), 7);
    checkOutput("load7.err", 32'(if10.load_err), 0);
    if10.load = 1'b0;
    applyStimulus(1);
    checkOutput("hold.digit", 32'(if10.digit), 7);

    // Clear beats load and count, and suppresses carry.
    if10.load     = 1'b1;
    if10.load_val = 4'd4;
    applyStimulus(1);
    if10.clr      = 1'b1;
    if10.load_val = 4'd2;
    if10.cnt_en   = 1'b1;
    #1;
    checkOutput("clr.carry", 32'(if10.carry_out), 0);
    applyStimulus(1);
    checkOutput("clr.digit", 32'(if10.digit), 0);
    if10.clr      = 1'b0;
    if10.cnt_en   = 1'b0;
    if10.load_val = 4'd9;
    applyStimulus(1);
    if10.load   = 1'b0;
    if10.clr    = 1'b1;
    if10.cnt_en = 1'b1;
    #1;
    checkOutput("clr9.carry", 32'(if10.carry_out), 0);
    applyStimulus(1);
    checkOutput("clr9.digit", 32'(if10.digit), 0);
    if10.clr    = 1'b0;
    if10.cnt_en = 1'b0;

    // Seconds cascade from 59.
    iflo.load     = 1'b1;
    iflo.load_val = 4'd9;
    ifhi.load     = 1'b1;
    ifhi.load_val = 4'd5;
    applyStimulus(1);
    iflo.load = 1'b0;
    ifhi.load = 1'b0;
    checkOutput("casc.lo59", 32'(iflo.digit), 9);
    checkOutput("casc.hi59", 32'(ifhi.digit), 5);
    iflo.cnt_en = 1'b1;
    #1;
    checkOutput("casc.lo_carry", 32'(iflo.carry_out), 1);
    checkOutput("casc.hi_carry", 32'(ifhi.carry_out), 1);
    applyStimulus(1);
    checkOutput("casc.lo00", 32'(iflo.digit), 0);
    checkOutput("casc.hi00", 32'(ifhi.digit), 0);
    applyStimulus(3);
    checkOutput("casc.lo3", 32'(iflo.digit), 3);
    iflo.load = 1'b1;
    applyStimulus(1);
    checkOutput("casc.load_no_ripple", 32'(ifhi.digit), 0);
    iflo.load = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("casc.rst_carry", 32'(iflo.carry_out), 0);
    applyStimulus(1);
    checkOutput("casc.rst_lo", 32'(iflo.digit), 0);
    checkOutput("casc.rst_hi", 32'(ifhi.digit), 0);
    checkOutput("casc.rst_lo_ssd", 32'(iflo.ssd), 32'h00);
    checkOutput("casc.rst_hi_ssd", 32'(ifhi.ssd), 32'h00);
    rst_n = 1'b1;
    iflo.cnt_en = 1'b0;
    applyStimulus(1);

    // Common-anode digit with blanking.
    if16.load     = 1'b1;
    if16.load_val = 4'd3;
    applyStimulus(1);
    checkOutput("al.ssd3", 32'(if16.ssd), 32'h30);
    if16.load   = 1'b0;
    if16.blank  = 1'b1;
    if16.cnt_en = 1'b1;
    applyStimulus(1);
    checkOutput("al.blank_digit", 32'(if16.digit), 4);
    checkOutput("al.blank_ssd", 32'(if16.ssd), 32'h7F);
    applyStimulus(1);
    checkOutput("al.blank_digit2", 32'(if16.digit), 5);
    if16.blank = 1'b0;
    applyStimulus(1);
    checkOutput("al.unblank_digit", 32'(if16.digit), 6);
    checkOutput("al.unblank_ssd", 32'(if16.ssd), 32'h02);
    if16.cnt_en   = 1'b0;
    if16.load     = 1'b1;
    if16.load_val = 4'd15;
    applyStimulus(1);
    checkOutput("al.ssdF", 32'(if16.ssd), 32'h0E);
    checkOutput("al.loadF_err", 32'(if16.load_err), 0);
    if16.load   = 1'b0;
    if16.cnt_en = 1'b1;
    #1;
    checkOutput("al.carryF", 32'(if16.carry_out), 1);
    applyStimulus(1);
    checkOutput("al.wrap", 32'(if16.digit), 0);
    checkOutput("al.wrap_ssd", 32'(if16.ssd), 32'h40);
    if16.cnt_en = 1'b0;

    applyStimulus(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
